// File: rtl/sdcard_pkg.sv
// Shared types and constants for the SD-card block-read DMA engine.
package sdcard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_TOKEN,
    ST_WAIT_TOKEN,
    ST_REQ_DATA,
    ST_WAIT_DATA,
    ST_REQ_CRC,
    ST_WAIT_CRC,
    ST_FINISH
  } sd_state_t;

  localparam logic [7:0] SD_TOKEN_START = 8'hFE;
  localparam logic [7:0] SD_POLL_BYTE   = 8'hFF;

  localparam logic [1:0] SD_ERR_OK      = 2'b00;
  localparam logic [1:0] SD_ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] SD_ERR_TOKEN   = 2'b10;
  localparam logic [1:0] SD_ERR_CRC     = 2'b11;

endpackage

// File: rtl/sdcard_crc16.sv
// Byte-wise combinational CRC16-CCITT update (poly 0x1021, MSB first).
// Only built when SDCARD_DMA_CRC_EN is defined, so no CRC logic exists otherwise.
`ifdef SDCARD_DMA_CRC_EN
module sdcard_crc16 (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] w_crc;

  always_comb begin
    w_crc = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (w_crc[15] ^ data_in[i])
        w_crc = {w_crc[14:0], 1'b0} ^ 16'h1021;
      else
        w_crc = {w_crc[14:0], 1'b0};
    end
    crc_out = w_crc;
  end

endmodule
`endif

// File: rtl/sdcard_dma.sv
// Streams one 512-byte SD data block from the SPI byte engine into the IDE sector buffer.
// Optional CRC16 checking of the block is enabled with the SDCARD_DMA_CRC_EN macro.
module sdcard_dma
  import sdcard_pkg::*;
#(
  parameter int TOKEN_TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       start,
  input  logic       abort,
  output logic       spi_req,
  input  logic       spi_ack,
  input  logic [7:0] spi_rx,
  output logic [7:0] sdcard_dma_data,
  output logic [8:0] sdcard_dma_addr,
  output logic       sdcard_dma_strobe,
  output logic       busy,
  output logic       done,
  output logic [1:0] err
);

  localparam logic [15:0] LP_TIMEOUT = 16'(TOKEN_TIMEOUT);

  sd_state_t   r_state;
  logic [15:0] r_poll_cnt;
  logic [9:0]  r_byte_cnt;
  logic        r_crc_idx;
  logic [1:0]  r_err;
  logic [7:0]  r_data;
  logic [8:0]  r_addr;
  logic        r_strobe;

`ifdef SDCARD_DMA_CRC_EN
  logic [15:0] r_crc;
  logic [7:0]  r_crc_hi;
  logic [15:0] w_crc_next;

  sdcard_crc16 u_crc16 (
    .crc_in  (r_crc),
    .data_in (spi_rx),
    .crc_out (w_crc_next)
  );
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state    <= ST_IDLE;
      r_poll_cnt <= '0;
      r_byte_cnt <= '0;
      r_crc_idx  <= 1'b0;
      r_err      <= SD_ERR_OK;
      r_data     <= '0;
      r_addr     <= '0;
      r_strobe   <= 1'b0;
`ifdef SDCARD_DMA_CRC_EN
      r_crc      <= '0;
      r_crc_hi   <= '0;
`endif
    end else begin
      r_strobe <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_err      <= SD_ERR_OK;
              r_poll_cnt <= '0;
              r_state    <= ST_REQ_TOKEN;
`ifdef SDCARD_DMA_CRC_EN
              r_crc      <= '0;
`endif
            end
          end
          ST_REQ_TOKEN: r_state <= ST_WAIT_TOKEN;
          ST_WAIT_TOKEN: begin
            if (spi_ack) begin
              if (spi_rx == SD_TOKEN_START) begin
                r_byte_cnt <= '0;
                r_state    <= ST_REQ_DATA;
              end else if (spi_rx[7:4] == 4'h0) begin
                r_err   <= SD_ERR_TOKEN;
                r_state <= ST_FINISH;
              end else if (r_poll_cnt == LP_TIMEOUT) begin
                r_err   <= SD_ERR_TIMEOUT;
                r_state <= ST_FINISH;
              end else begin
                r_poll_cnt <= r_poll_cnt + 16'd1;
                r_state    <= ST_REQ_TOKEN;
              end
            end
          end
          ST_REQ_DATA: r_state <= ST_WAIT_DATA;
          ST_WAIT_DATA: begin
            if (spi_ack) begin
              r_strobe <= 1'b1;
              r_data   <= spi_rx;
              r_addr   <= r_byte_cnt[8:0];
`ifdef SDCARD_DMA_CRC_EN
              r_crc    <= w_crc_next;
`endif
              if (r_byte_cnt == 10'd511) begin
                r_crc_idx <= 1'b0;
                r_state   <= ST_REQ_CRC;
              end else begin
                r_byte_cnt <= r_byte_cnt + 10'd1;
                r_state    <= ST_REQ_DATA;
              end
            end
          end
          ST_REQ_CRC: r_state <= ST_WAIT_CRC;
          ST_WAIT_CRC: begin
            if (spi_ack) begin
              if (!r_crc_idx) begin
                r_crc_idx <= 1'b1;
`ifdef SDCARD_DMA_CRC_EN
                r_crc_hi  <= spi_rx;
`endif
                r_state   <= ST_REQ_CRC;
              end else begin
`ifdef SDCARD_DMA_CRC_EN
                // Resolved on entry to FINISH so err is already valid in the done cycle.
                if ({r_crc_hi, spi_rx} != r_crc && r_err == SD_ERR_OK)
                  r_err <= SD_ERR_CRC;
`endif
                r_state <= ST_FINISH;
              end
            end
          end
          ST_FINISH: r_state <= ST_IDLE;
          default:   r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi_req = (r_state == ST_REQ_TOKEN) || (r_state == ST_REQ_DATA) ||
                   (r_state == ST_REQ_CRC);
  assign busy    = (r_state != ST_IDLE) && (r_state != ST_FINISH);
  assign done    = (r_state == ST_FINISH) && !abort;
  assign err     = r_err;

  assign sdcard_dma_data   = r_data;
  assign sdcard_dma_addr   = r_addr;
  assign sdcard_dma_strobe = r_strobe;

endmodule

// File: tb/tb_sdcard_dma.sv
// Directed self-checking bench for sdcard_dma; SDCARD_DMA_CRC_EN selects the CRC expectation.
module tb_sdcard_dma;
  import sdcard_pkg::*;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       spi_ack = 1'b0;
  logic [7:0] spi_rx = 8'h00;
  logic       spi_req;
  logic [7:0] sdcard_dma_data;
  logic [8:0] sdcard_dma_addr;
  logic       sdcard_dma_strobe;
  logic       busy;
  logic       done;
  logic [1:0] err;

  sdcard_dma #(.TOKEN_TIMEOUT(4)) dut (
    .clk               (clk),
    .reset_            (reset_),
    .start             (start),
    .abort             (abort),
    .spi_req           (spi_req),
    .spi_ack           (spi_ack),
    .spi_rx            (spi_rx),
    .sdcard_dma_data   (sdcard_dma_data),
    .sdcard_dma_addr   (sdcard_dma_addr),
    .sdcard_dma_strobe (sdcard_dma_strobe),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Strobe/done monitor; blk_base is written only by the main sequence.
  int strobe_cnt = 0;
  int bad_cnt = 0;
  int done_cnt = 0;
  int blk_base = 0;
  int idx;

  always @(negedge clk) begin
    if (sdcard_dma_strobe) begin
      idx = strobe_cnt - blk_base;
      if (sdcard_dma_addr !== idx[8:0] || sdcard_dma_data !== idx[7:0]) begin
        bad_cnt++;
        $display("FAIL strobe_payload: got addr=%0d data=%02h expected addr=%0d data=%02h",
                 sdcard_dma_addr, sdcard_dma_data, idx[8:0], idx[7:0]);
      end
      strobe_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Answer one SPI request: wait (bounded) for spi_req, then ack one cycle later.
  task automatic feed(input logic [7:0] b, input bit st);
    int k;
    k = 0;
    while (spi_req !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("spi_req_seen", {31'd0, spi_req}, 32'd1);
    @(negedge clk);
    spi_ack = 1'b1;
    spi_rx  = b;
    start   = st;
    @(negedge clk);
    spi_ack = 1'b0;
    start   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed_data(input int n);
    for (int i = 0; i < n; i++) feed(8'(i), i == 10);
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int j = 0; j < 8; j++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  logic [15:0] good_crc;
  logic [1:0]  exp_bad_crc_err;
  int          d0;

  initial begin
    good_crc = 16'h0000;
    for (int i = 0; i < 512; i++) good_crc = crc_byte(good_crc, 8'(i));
`ifdef SDCARD_DMA_CRC_EN
    exp_bad_crc_err = SD_ERR_CRC;
`else
    exp_bad_crc_err = SD_ERR_OK;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_req", {31'd0, spi_req}, 32'd0);
    chk("rst_strobe", {31'd0, sdcard_dma_strobe}, 32'd0);
    chk("rst_outs", {19'd0, err, sdcard_dma_addr, 2'b00}, 32'd0);
    chk("rst_data", {24'd0, sdcard_dma_data}, 32'd0);
    reset_ = 1'b1;
    @(negedge clk);

    // Stray ack in IDLE is ignored
    spi_ack = 1'b1;
    spi_rx  = SD_TOKEN_START;
    @(negedge clk);
    spi_ack = 1'b0;
    @(negedge clk);
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_req", {31'd0, spi_req}, 32'd0);
    chk("stray_strobe_cnt", strobe_cnt, 32'd0);

    // Nominal block, with a start pulse mid-block that must be ignored
    blk_base = strobe_cnt;
    d0 = done_cnt;
    pulse_start();
    chk("busy_rise", {31'd0, busy}, 32'd1);
    repeat (3) feed(SD_POLL_BYTE, 1'b0);
    feed(SD_TOKEN_START, 1'b0);
    feed(8'h00, 1'b0);
    chk("strobe_latency", {22'd0, sdcard_dma_strobe, sdcard_dma_addr}, 32'h200);
    for (int i = 1; i < 512; i++) feed(8'(i), i == 10);
    feed(good_crc[15:8], 1'b0);
    feed(good_crc[7:0], 1'b0);
    chk("nom_done", {31'd0, done}, 32'd1);
    chk("nom_busy_low", {31'd0, busy}, 32'd0);
    chk("nom_err", {30'd0, err}, {30'd0, SD_ERR_OK});
    chk("nom_strobes", strobe_cnt - blk_base, 32'd512);
    chk("nom_payload_bad", bad_cnt, 32'd0);
    // start coinciding with done is ignored
    pulse_start();
    chk("start_on_done_busy", {31'd0, busy}, 32'd0);
    chk("start_on_done_req", {31'd0, spi_req}, 32'd0);
    chk("nom_done_count", done_cnt - d0, 32'd1);

    // Token timeout with TOKEN_TIMEOUT=4: done after the fifth poll byte
    blk_base = strobe_cnt;
    pulse_start();
    repeat (4) feed(SD_POLL_BYTE, 1'b0);
    chk("to_not_yet", {30'd0, busy, done}, 32'd2);
    feed(SD_POLL_BYTE, 1'b0);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_err", {30'd0, err}, {30'd0, SD_ERR_TIMEOUT});
    chk("to_strobes", strobe_cnt - blk_base, 32'd0);
    @(negedge clk);

    // Data-error token
    blk_base = strobe_cnt;
    pulse_start();
    feed(SD_POLL_BYTE, 1'b0);
    feed(8'h08, 1'b0);
    chk("tok_done", {31'd0, done}, 32'd1);
    chk("tok_err", {30'd0, err}, {30'd0, SD_ERR_TOKEN});
    chk("tok_strobes", strobe_cnt - blk_base, 32'd0);
    @(negedge clk);
    chk("tok_err_held", {30'd0, err}, {30'd0, SD_ERR_TOKEN});

    // CRC mismatch
    blk_base = strobe_cnt;
    pulse_start();
    chk("crc_err_cleared", {30'd0, err}, 32'd0);
    feed(SD_TOKEN_START, 1'b0);
    feed_data(512);
    feed(8'h00, 1'b0);
    feed(8'h00, 1'b0);
    chk("crc_done", {31'd0, done}, 32'd1);
    chk("crc_err", {30'd0, err}, {30'd0, exp_bad_crc_err});
    chk("crc_strobes", strobe_cnt - blk_base, 32'd512);
    @(negedge clk);

    // Abort after byte 100: strobe for byte 100 still fires, no done
    blk_base = strobe_cnt;
    d0 = done_cnt;
    pulse_start();
    feed(SD_TOKEN_START, 1'b0);
    feed_data(101);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_req", {31'd0, spi_req}, 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_strobes", strobe_cnt - blk_base, 32'd101);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    blk_base = strobe_cnt;
    pulse_start();
    feed(SD_TOKEN_START, 1'b0);
    feed_data(512);
    feed(good_crc[15:8], 1'b0);
    feed(good_crc[7:0], 1'b0);
    chk("post_abort_done", {31'd0, done}, 32'd1);
    chk("post_abort_strobes", strobe_cnt - blk_base, 32'd512);
    @(negedge clk);

    // Reset mid-block: outputs drop at once, no done
    blk_base = strobe_cnt;
    d0 = done_cnt;
    pulse_start();
    feed(SD_TOKEN_START, 1'b0);
    feed_data(101);
    #2 reset_ = 1'b0;
    #1;
    chk("rstmid_strobe", {31'd0, sdcard_dma_strobe}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_addr_data", {15'd0, sdcard_dma_addr, sdcard_dma_data}, 32'd0);
    chk("rstmid_req", {31'd0, spi_req}, 32'd0);
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    chk("rstmid_no_done", done_cnt - d0, 32'd0);
    blk_base = strobe_cnt;
    pulse_start();
    feed(SD_TOKEN_START, 1'b0);
    feed_data(512);
    feed(good_crc[15:8], 1'b0);
    feed(good_crc[7:0], 1'b0);
    chk("post_rst_done", {31'd0, done}, 32'd1);
    chk("post_rst_err", {30'd0, err}, 32'd0);
    chk("post_rst_strobes", strobe_cnt - blk_base, 32'd512);
    chk("all_payload_bad", bad_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
